// File: rtl/inst_loader.sv
// inst_loader
//   Instruction-memory writer. Packs a byte stream (low byte first) into
//   DW-bit instructions and writes them to consecutive instruction-RAM
//   addresses starting at 0. Holds the CPU off until a load has finished.
//
// Ports
//   Clk        rising-edge clock
//   Reset      synchronous, active-low reset
//   Start      begin a load (honoured only when idle or done)
//   LoadLen    instruction count, captured with Start, clamped to 2**IW
//   ByteIn     stream byte
//   ByteValid  ByteIn valid; a transfer happens when ByteValid && ByteReady
//   ByteReady  loader accepts a byte this cycle
//   WrEn       one-cycle RAM write strobe
//   WrAddr     RAM write address
//   WrData     RAM write data
//   Busy       load in progress
//   Done       load complete, held until the next Start or reset
//   Err        a high byte carried nonzero bits above DW (dropped)
//   CpuHold    keep the CPU program counter in reset
module inst_loader #(
  parameter int IW = 10,
  parameter int DW = 9
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW:0]   LoadLen,
  input  logic [7:0]    ByteIn,
  input  logic          ByteValid,
  output logic          ByteReady,
  output logic          WrEn,
  output logic [IW-1:0] WrAddr,
  output logic [DW-1:0] WrData,
  output logic          Busy,
  output logic          Done,
  output logic          Err,
  output logic          CpuHold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [IW:0] MAX_LEN = {1'b1, {IW{1'b0}}};
  localparam logic [IW:0] ONE     = {{IW{1'b0}}, 1'b1};
  // High-byte bits that do not fit into the instruction word.
  localparam logic [7:0]  DROP_MASK = 8'hFF << (DW - 8);

  state_t        state;
  state_t        state_nx;
  logic [IW:0]   len;
  logic [IW-1:0] addr;
  logic [DW-1:0] data;
  logic          err;

  logic [IW:0]   len_clamped;
  logic          xfer;
  logic          last_word;

  assign len_clamped = (LoadLen > MAX_LEN) ? MAX_LEN : LoadLen;
  assign xfer        = ByteValid && ByteReady;
  // The address doubles as the word count; widen so 2**IW is reachable.
  assign last_word   = (({1'b0, addr} + ONE) == len);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (Start) state_nx = (len_clamped == '0) ? S_DONE : S_LO;
      end
      S_LO: begin
        if (xfer) state_nx = S_HI;
      end
      S_HI: begin
        if (xfer) state_nx = S_WRITE;
      end
      S_WRITE: begin
        state_nx = last_word ? S_DONE : S_LO;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ByteReady = 1'b0;
    WrEn      = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    CpuHold   = 1'b1;
    unique case (state)
      S_LO, S_HI: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
      end
      S_WRITE: begin
        WrEn = 1'b1;
        Busy = 1'b1;
      end
      S_DONE: begin
        Done    = 1'b1;
        CpuHold = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= S_IDLE;
      len   <= '0;
      addr  <= '0;
      data  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            len  <= len_clamped;
            addr <= '0;
            err  <= 1'b0;
          end
        end
        S_LO: begin
          if (xfer) data[7:0] <= ByteIn;
        end
        S_HI: begin
          if (xfer) begin
            data[DW-1:8] <= ByteIn[DW-9:0];
            if ((ByteIn & DROP_MASK) != 8'h00) err <= 1'b1;
          end
        end
        S_WRITE: begin
          if (!last_word) addr <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign WrAddr = addr;
  assign WrData = data;
  assign Err    = err;

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: directed byte streams, a queue-based model of
// the expected RAM writes, and one compare process checking every cycle.
module tb_inst_loader;
  localparam int IW = 10;
  localparam int DW = 9;
  localparam int DEPTH = 1 << IW;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic [IW:0]   LoadLen = '0;
  logic [7:0]    ByteIn = '0;
  logic          ByteValid = 1'b0;
  logic          ByteReady;
  logic          WrEn;
  logic [IW-1:0] WrAddr;
  logic [DW-1:0] WrData;
  logic          Busy;
  logic          Done;
  logic          Err;
  logic          CpuHold;

  inst_loader #(.IW(IW), .DW(DW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .LoadLen(LoadLen),
    .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy),
    .Done(Done), .Err(Err), .CpuHold(CpuHold)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur", name);
  endtask

  // Model: queue of writes the RAM must see, in order.
  int   exp_addr[$];
  int   exp_data[$];
  int   words_left = 0;
  bit   done_due = 0;
  int   wr_count = 0;
  int   last_addr = -1;
  int   last_data = -1;
  bit   gap_check = 0;
  int   cyc = 0;
  int   last_wr_cyc = -1;
  bit   exp_err = 0;
  logic [7:0] lo_b [DEPTH];
  logic [7:0] hi_b [DEPTH];

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (Reset) begin
      chk("cpuhold_vs_done", {31'b0, CpuHold}, {31'b0, !Done});
      if (WrEn) chk("ready_in_write", {31'b0, ByteReady}, 32'd0);
      if (done_due) begin
        chk("done_after_last", {31'b0, Done}, 32'd1);
        chk("cpuhold_after_last", {31'b0, CpuHold}, 32'd0);
        chk("busy_after_last", {31'b0, Busy}, 32'd0);
        done_due = 0;
      end
      if (WrEn) begin
        if (exp_addr.size() == 0) begin
          fail_now("unexpected_wren");
        end else begin
          chk("wr_addr", 32'(WrAddr), exp_addr.pop_front());
          chk("wr_data", 32'(WrData), exp_data.pop_front());
          if (gap_check && last_wr_cyc >= 0) chk("wren_spacing", cyc - last_wr_cyc, 32'd3);
          last_wr_cyc = cyc;
          wr_count++;
          last_addr = int'(WrAddr);
          last_data = int'(WrData);
          words_left--;
          if (words_left == 0) done_due = 1;
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic start_load(input int len);
    logic [31:0] l;
    l = len;
    @(negedge Clk);
    Start = 1'b1;
    LoadLen = l[IW:0];
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    ByteIn = b;
    ByteValid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge Clk);
      if (ByteReady) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("byte_ready_timeout");
    else begin
      @(posedge Clk);
      #1;
    end
    ByteValid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge Clk);
      if (Done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("done_timeout");
  endtask

  // Full load of words taken from lo_b/hi_b; optional Start pulse while busy.
  task automatic do_load(input int len, input int gap, input int pulse_word);
    int n;
    logic [15:0] w;
    n = (len > DEPTH) ? DEPTH : len;
    exp_err = 0;
    last_wr_cyc = -1;
    wr_count = 0;
    words_left = n;
    start_load(len);
    if (n > 0) chk("ready_after_start", {31'b0, ByteReady}, 32'd1);
    for (int i = 0; i < n; i++) begin
      w = {hi_b[i], lo_b[i]};
      exp_addr.push_back(i);
      exp_data.push_back(int'(w[DW-1:0]));
      if ((hi_b[i] >> (DW - 8)) != 8'h00) exp_err = 1;
      send_byte(lo_b[i]);
      if (i == pulse_word) begin
        @(negedge Clk);
        Start = 1'b1;
        LoadLen = 11'd1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
      end
      idle_cycles(gap);
      send_byte(hi_b[i]);
      idle_cycles(gap);
    end
    wait_done();
    chk("err_flag", {31'b0, Err}, {31'b0, exp_err});
    chk("write_count", wr_count, n);
    chk("queue_drained", exp_addr.size(), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_byte_ready", {31'b0, ByteReady}, 32'd0);
    chk("rst_wren", {31'b0, WrEn}, 32'd0);
    chk("rst_wraddr", 32'(WrAddr), 32'd0);
    chk("rst_wrdata", 32'(WrData), 32'd0);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_err", {31'b0, Err}, 32'd0);
    chk("rst_cpuhold", {31'b0, CpuHold}, 32'd1);
    Reset = 1'b1;
    idle_cycles(1);

    // Back-to-back three-word load.
    lo_b[0] = 8'hE0; hi_b[0] = 8'h00;
    lo_b[1] = 8'hB0; hi_b[1] = 8'h00;
    lo_b[2] = 8'h91; hi_b[2] = 8'h00;
    gap_check = 1;
    do_load(3, 0, -1);
    gap_check = 0;
    chk("t1_last_addr", last_addr, 32'd2);
    chk("t1_last_data", last_data, 32'h091);
    // Bytes offered in DONE must be ignored.
    ByteValid = 1'b1;
    idle_cycles(3);
    ByteValid = 1'b0;
    chk("done_ignores_bytes", {31'b0, Done}, 32'd1);

    // Gapped stream, same contents.
    do_load(2, 1, -1);
    chk("t2_last_addr", last_addr, 32'd1);
    chk("t2_last_data", last_data, 32'h0B0);

    // Overflow bits in the high byte.
    lo_b[0] = 8'h5A; hi_b[0] = 8'h03;
    lo_b[1] = 8'h11; hi_b[1] = 8'h00;
    do_load(2, 0, -1);
    chk("t3_err_set", {31'b0, Err}, 32'd1);
    chk("t3_last_data", last_data, 32'h011);

    // Zero-length load: Done the cycle after Start, Err cleared.
    start_load(0);
    chk("len0_done", {31'b0, Done}, 32'd1);
    chk("len0_busy", {31'b0, Busy}, 32'd0);
    chk("t3_err_cleared", {31'b0, Err}, 32'd0);
    idle_cycles(4);

    // Over-long length clamps to the full memory.
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] v;
      v = i;
      lo_b[i] = v[7:0];
      hi_b[i] = {7'b0, v[8]};
    end
    do_load(DEPTH + 5, 0, -1);
    chk("clamp_last_addr", last_addr, 32'd1023);
    chk("clamp_count", wr_count, 32'd1024);
    chk("clamp_last_data", last_data, 32'h1FF);

    // Reset after 1.5 words of a 4-word load.
    lo_b[0] = 8'h21; hi_b[0] = 8'h01;
    lo_b[1] = 8'h22; hi_b[1] = 8'h00;
    lo_b[2] = 8'h23; hi_b[2] = 8'h01;
    lo_b[3] = 8'h24; hi_b[3] = 8'h00;
    wr_count = 0;
    words_left = 4;
    start_load(4);
    exp_addr.push_back(0);
    exp_data.push_back(32'h121);
    send_byte(lo_b[0]);
    send_byte(hi_b[0]);
    send_byte(lo_b[1]);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    words_left = 0;
    done_due = 0;
    chk("rstmid_writes", wr_count, 32'd1);
    chk("rstmid_queue", exp_addr.size(), 32'd0);
    chk("rstmid_busy", {31'b0, Busy}, 32'd0);
    chk("rstmid_cpuhold", {31'b0, CpuHold}, 32'd1);
    chk("rstmid_done", {31'b0, Done}, 32'd0);
    chk("rstmid_ready", {31'b0, ByteReady}, 32'd0);
    chk("rstmid_addr", 32'(WrAddr), 32'd0);
    Reset = 1'b1;
    idle_cycles(2);
    chk("rstmid_idle_wren", {31'b0, WrEn}, 32'd0);
    do_load(4, 0, -1);
    chk("reload_last_addr", last_addr, 32'd3);

    // Start pulsed while busy is ignored.
    lo_b[0] = 8'h01; hi_b[0] = 8'h00;
    lo_b[1] = 8'h02; hi_b[1] = 8'h01;
    lo_b[2] = 8'h03; hi_b[2] = 8'h00;
    do_load(3, 0, 1);
    chk("busy_start_last_addr", last_addr, 32'd2);
    chk("busy_start_last_data", last_data, 32'h003);

    idle_cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
